// File: rtl/sequence_show_scheduler_if.sv
// Bundle of game-FSM control, sequence-memory read port and LED/status signals
// for sequence_show_scheduler. master = surrounding system, slave = scheduler.
interface sequence_show_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  start;
  logic                  abort;
  logic                  speed;
  logic [ADDR_WIDTH-1:0] last_index;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] led_out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, speed, last_index, mem_data,
    input  mem_rd, mem_addr, led_out, busy, done
  );

  modport slave (
    input  start, abort, speed, last_index, mem_data,
    output mem_rd, mem_addr, led_out, busy, done
  );
endinterface

// File: rtl/sequence_show_scheduler.sv
// Plays the stored colour sequence on the LEDs: fetch, light for ON cycles, blank for GAP.
// Optional feature macro: SEQ_SHOW_PAUSE_EN adds pause_i, which freezes the LED phases.
module sequence_show_scheduler #(
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned CNT_WIDTH      = 25,
  parameter int unsigned ON_CYCLES_SLOW = 25_000_000,
  parameter int unsigned ON_CYCLES_FAST = 12_500_000,
  parameter int unsigned GAP_CYCLES     = 5_000_000
) (
  input logic                      clk_i,
  input logic                      rst_i,
`ifdef SEQ_SHOW_PAUSE_EN
  input logic                      pause_i,
`endif
  sequence_show_scheduler_if.slave bus
);

  // Timer reload values are ON-1 / GAP-1, so each parameter must lie in 1..2^CNT_WIDTH.
  localparam longint unsigned CNT_SPAN = longint'(1) << CNT_WIDTH;

  if (ON_CYCLES_SLOW < 1 || longint'(ON_CYCLES_SLOW) > CNT_SPAN ||
      ON_CYCLES_FAST < 1 || longint'(ON_CYCLES_FAST) > CNT_SPAN ||
      GAP_CYCLES < 1     || longint'(GAP_CYCLES) > CNT_SPAN) begin : g_bad_timing
    $error("sequence_show_scheduler: ON/GAP cycle counts must be in 1..2**CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] ON_SLOW_LD = CNT_WIDTH'(ON_CYCLES_SLOW - 1);
  localparam logic [CNT_WIDTH-1:0] ON_FAST_LD = CNT_WIDTH'(ON_CYCLES_FAST - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LD     = CNT_WIDTH'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_LED_ON    = 3'd3,
    S_LED_GAP   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic                  speed_q;
  logic [CNT_WIDTH-1:0]  timer_q;
  logic [DATA_WIDTH-1:0] led_q;
  logic                  mem_rd_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  hold_s;
  logic [CNT_WIDTH-1:0]  on_load_s;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [CNT_WIDTH-1:0]  timer_dec_s;

`ifdef SEQ_SHOW_PAUSE_EN
  assign hold_s = pause_i;
`else
  assign hold_s = 1'b0;
`endif

  assign on_load_s   = speed_q ? ON_FAST_LD : ON_SLOW_LD;
  assign addr_d      = addr_q + ADDR_WIDTH'(1);
  assign timer_dec_s = timer_q - CNT_WIDTH'(1);

  // Playback FSM; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      speed_q  <= 1'b0;
      timer_q  <= '0;
      led_q    <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.abort && state_q != S_IDLE) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      timer_q  <= '0;
      led_q    <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            speed_q  <= bus.speed;
            last_q   <= bus.last_index;
            addr_q   <= '0;
            mem_rd_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_FETCH;
          end else begin
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        S_FETCH: begin
          mem_rd_q <= 1'b0;
          state_q  <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          led_q   <= bus.mem_data;
          timer_q <= on_load_s;
          state_q <= S_LED_ON;
        end
        S_LED_ON: begin
          if (hold_s) begin
            timer_q <= timer_q;
          end else if (timer_q == '0) begin
            led_q   <= '0;
            timer_q <= GAP_LD;
            state_q <= S_LED_GAP;
          end else begin
            timer_q <= timer_dec_s;
          end
        end
        S_LED_GAP: begin
          // Compare before incrementing so last_index = all-ones never wraps.
          if (hold_s) begin
            timer_q <= timer_q;
          end else if (timer_q == '0) begin
            if (addr_q == last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              addr_q   <= addr_d;
              mem_rd_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end else begin
            timer_q <= timer_dec_s;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          led_q    <= '0;
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = addr_q;
  assign bus.led_out  = led_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_sequence_show_scheduler.sv
// Bench for sequence_show_scheduler: timeline model of the playback plus directed scenarios.
module tb_sequence_show_scheduler;
  localparam int ON_SLOW = 4;
  localparam int ON_FAST = 2;
  localparam int GAP     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  always #5 clk = ~clk;

  sequence_show_scheduler_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5)) bus_if ();

  sequence_show_scheduler #(
    .DATA_WIDTH(4), .ADDR_WIDTH(5), .CNT_WIDTH(25),
    .ON_CYCLES_SLOW(ON_SLOW), .ON_CYCLES_FAST(ON_FAST), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
`ifdef SEQ_SHOW_PAUSE_EN
    .pause_i(pause),
`endif
    .bus(bus_if)
  );

  logic [3:0] mem [32];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_start = 0;
  bit chk_en = 1'b0;

  // Event logs, cycle numbers relative to the start-sampling edge (cycle 0)
  int rd_log[$];
  int done_log[$];
  int led_cyc[$];
  int led_val[$];

  // Model: a playback is a timeline position k; item i spans (2+ON+GAP) positions
  bit m_active = 1'b0;
  int m_k = 0;
  int m_on = ON_SLOW;
  int m_n = 1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus_if.mem_rd) bus_if.mem_data <= mem[bus_if.mem_addr];
  end

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (bus_if.abort) m_active <= 1'b0;
      else if (m_k == m_n * (2 + m_on + GAP)) m_active <= 1'b0;
      else if (!(pause && (m_k % (2 + m_on + GAP)) >= 2)) m_k <= m_k + 1;
    end else if (bus_if.start && !bus_if.abort) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_on     <= bus_if.speed ? ON_FAST : ON_SLOW;
      m_n      <= int'(bus_if.last_index) + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t_start);
    end
  endtask

  int len, idx, p;
  logic e_rd, e_busy, e_done;
  logic [4:0] e_addr;
  logic [3:0] e_led;

  always @(negedge clk) begin
    e_rd = 1'b0; e_addr = 5'd0; e_led = 4'd0; e_busy = 1'b0; e_done = 1'b0;
    if (m_active) begin
      len = 2 + m_on + GAP;
      e_busy = 1'b1;
      if (m_k == m_n * len) begin
        e_done = 1'b1;
      end else begin
        idx = m_k / len;
        p = m_k % len;
        e_rd = (p == 0);
        e_addr = 5'(idx);
        if (p >= 2 && p < 2 + m_on) e_led = mem[idx];
      end
    end
    if (chk_en) begin
      chk("mem_rd", bus_if.mem_rd, e_rd);
      chk("led_out", bus_if.led_out, e_led);
      chk("busy", bus_if.busy, e_busy);
      chk("done", bus_if.done, e_done);
      if (e_rd) chk("mem_addr", bus_if.mem_addr, e_addr);
      if (bus_if.mem_rd === 1'b1) rd_log.push_back(cyc - t_start);
      if (bus_if.done === 1'b1) done_log.push_back(cyc - t_start);
      if (bus_if.led_out !== 4'd0) begin
        led_cyc.push_back(cyc - t_start);
        led_val.push_back(int'(bus_if.led_out));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic spd, input logic [4:0] last);
    bus_if.start = 1'b1;
    bus_if.speed = spd;
    bus_if.last_index = last;
    t_start = cyc;
    rd_log.delete(); done_log.delete(); led_cyc.delete(); led_val.delete();
    step(1);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (bus_if.done === 1'b1) seen = 1'b1;
    end
    chk("done_timeout", seen, 1);
    step(2);
  endtask

  function automatic int led_count(input int v);
    int c = 0;
    foreach (led_val[i]) if (led_val[i] == v) c++;
    return c;
  endfunction

  function automatic int led_first(input int v);
    foreach (led_val[i]) if (led_val[i] == v) return led_cyc[i];
    return -1;
  endfunction

  initial begin
    bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.speed = 1'b0;
    bus_if.last_index = 5'd0;
    foreach (mem[i]) mem[i] = 4'd0;
    mem[0] = 4'd3; mem[1] = 4'd5; mem[2] = 4'd9;
    step(1);
    chk_en = 1'b1;
    step(2);
    chk("rst_mem_addr", bus_if.mem_addr, 0);
    chk("rst_led", bus_if.led_out, 0);
    chk("rst_busy", bus_if.busy, 0);
    rst = 1'b0;
    step(2);

    // 1: slow playback of {3,5,9}
    pulse_start(1'b0, 5'd2);
    wait_done(40);
    chk("t1_rd_cnt", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("t1_rd0", rd_log[0], 1);
      chk("t1_rd1", rd_log[1], 9);
      chk("t1_rd2", rd_log[2], 17);
    end
    chk("t1_led3_first", led_first(3), 3);
    chk("t1_led3_cnt", led_count(3), 4);
    chk("t1_led5_first", led_first(5), 11);
    chk("t1_led9_first", led_first(9), 19);
    chk("t1_led9_cnt", led_count(9), 4);
    chk("t1_done_cnt", done_log.size(), 1);
    if (done_log.size() == 1) chk("t1_done_cyc", done_log[0], 25);

    // 2: fast playback
    pulse_start(1'b1, 5'd2);
    wait_done(40);
    chk("t2_led5_cnt", led_count(5), 2);
    if (done_log.size() == 1) chk("t2_done_cyc", done_log[0], 19);
    else chk("t2_done_cnt", done_log.size(), 1);

    // 3: single item
    mem[0] = 4'd4;
    pulse_start(1'b0, 5'd0);
    wait_done(20);
    step(3);
    chk("t3_rd_cnt", rd_log.size(), 1);
    chk("t3_led4_cnt", led_count(4), 4);
    chk("t3_done_cnt", done_log.size(), 1);
    mem[0] = 4'd3;

    // 4: abort at cycle 12, then a fresh start
    pulse_start(1'b0, 5'd2);
    step(11);
    bus_if.abort = 1'b1;
    step(1);
    bus_if.abort = 1'b0;
    chk("t4_busy", bus_if.busy, 0);
    chk("t4_led", bus_if.led_out, 0);
    step(20);
    chk("t4_no_done", done_log.size(), 0);
    bus_if.abort = 1'b1;
    step(2);
    chk("t4_idle_abort_busy", bus_if.busy, 0);
    bus_if.abort = 1'b0;
    pulse_start(1'b0, 5'd2);
    wait_done(40);
    if (done_log.size() == 1) chk("t4_restart_done", done_log[0], 25);
    else chk("t4_restart_done_cnt", done_log.size(), 1);

    // 5: start re-pulse and input changes mid-play, then reset mid-play
    pulse_start(1'b0, 5'd2);
    step(4);
    bus_if.start = 1'b1; bus_if.speed = 1'b1; bus_if.last_index = 5'd0;
    step(1);
    bus_if.start = 1'b0;
    step(4);
    bus_if.speed = 1'b0;
    wait_done(40);
    chk("t5_rd_cnt", rd_log.size(), 3);
    if (done_log.size() == 1) chk("t5_done_cyc", done_log[0], 25);
    else chk("t5_done_cnt", done_log.size(), 1);
    pulse_start(1'b0, 5'd2);
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_rst_addr", bus_if.mem_addr, 0);
    chk("t5_rst_busy", bus_if.busy, 0);
    chk("t5_rst_rd", bus_if.mem_rd, 0);
    step(20);
    chk("t5_rst_no_done", done_log.size(), 0);

    // Full address range: last_index = 31 must not wrap
    foreach (mem[i]) mem[i] = 4'((i * 7 + 1) % 16);
    pulse_start(1'b1, 5'd31);
    wait_done(260);
    chk("full_rd_cnt", rd_log.size(), 32);
    if (done_log.size() == 1) chk("full_done_cyc", done_log[0], 193);
    else chk("full_done_cnt", done_log.size(), 1);
    mem[0] = 4'd3; mem[1] = 4'd5; mem[2] = 4'd9;

`ifdef SEQ_SHOW_PAUSE_EN
    // 6: pause for 3 cycles in the first LED_ON
    pulse_start(1'b0, 5'd2);
    step(3);
    pause = 1'b1;
    step(3);
    pause = 1'b0;
    wait_done(40);
    chk("t6_led3_cnt", led_count(3), 7);
    if (done_log.size() == 1) chk("t6_done_cyc", done_log[0], 28);
    else chk("t6_done_cnt", done_log.size(), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
